// File: rtl/rect_draw_sched.sv
// rect_draw_sched
//   Round-robin arbiter and rectangle rasteriser for the vga_adapter pixel
//   write port. Each requester presents a rectangle descriptor. One requester
//   is granted at a time, and its rectangle is walked row-major at one pixel
//   per clock.
//
// Optional feature: define GLYPH_MASK_EN to add the req_mask port. Each
//   pixel is then coloured through a 10x10 glyph bitmap instead of a solid
//   fill.
//
// Ports
//   clk       pixel clock (same clock as vga_adapter)
//   rst       asynchronous, active-low reset
//   req       request level per requester; held until its gnt bit
//   req_rect  descriptor per requester, slot i at [i*RW +: RW]
//             fields MSB..LSB: x0[XW] y0[YW] w[XW] h[YW] color[3]
//   req_mask  10x10 glyph bitmap per requester, slot i at [i*100 +: 100]
//             (GLYPH_MASK_EN only)
//   gnt       one-cycle one-hot pulse; the descriptor is latched on this edge
//   done      one-cycle one-hot pulse after the rectangle's last pixel
//   busy      high from grant through the done cycle
//   x/y/color/plot  registered pixel write to vga_adapter
module rect_draw_sched #(
    parameter int NREQ = 3,
    parameter int XW   = 9,
    parameter int YW   = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NREQ-1:0]                req,
    input  logic [NREQ*(2*XW+2*YW+3)-1:0]  req_rect,
`ifdef GLYPH_MASK_EN
    input  logic [NREQ*100-1:0]            req_mask,
`endif
    output logic [NREQ-1:0]                gnt,
    output logic [NREQ-1:0]                done,
    output logic                           busy,
    output logic [XW-1:0]                  x,
    output logic [YW-1:0]                  y,
    output logic [2:0]                     color,
    output logic                           plot
);

    localparam int RW = 2*XW + 2*YW + 3;
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    // Visible screen size; coordinates at or beyond these are clipped.
    localparam logic [XW:0] SCR_W = (XW+1)'(320);
    localparam logic [YW:0] SCR_H = (YW+1)'(240);

    typedef struct packed {
        logic [XW-1:0] x0;
        logic [YW-1:0] y0;
        logic [XW-1:0] w;
        logic [YW-1:0] h;
        logic [2:0]    color;
    } rect_t;

    typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

    state_t          state, state_nx;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   win;
    logic            win_vld;
    logic [NREQ-1:0] win_oh;
    rect_t           slot;
    rect_t           cur;
    logic [NREQ-1:0] cur_oh;
    logic [XW-1:0]   col;
    logic [YW-1:0]   row;
    logic            pend;       // pixels of the current rectangle remain
    logic [XW:0]     px;         // one extra bit so x0+col never wraps
    logic [YW:0]     py;
    logic            clip;
    logic            last_pix;
    logic [2:0]      pix_color;

    // (base + off) mod NREQ, for off < NREQ
    function automatic logic [PW-1:0] rr_add(input logic [PW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NREQ) s = s - NREQ;
        return PW'(s);
    endfunction

    // Round-robin search upward from ptr. The loop runs from the farthest
    // offset down to zero, so the closest requesting slot wins.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
        win     = '0;
        win_vld = 1'b0;
        for (int i = NREQ-1; i >= 0; i--) begin
            if (req[rr_add(ptr, i)]) begin
                win     = rr_add(ptr, i);
                win_vld = 1'b1;
            end
        end
    end

    assign win_oh = NREQ'(1) << win;
    assign slot   = rect_t'(req_rect[int'(win)*RW +: RW]);

    assign px       = {1'b0, cur.x0} + {1'b0, col};
    assign py       = {1'b0, cur.y0} + {1'b0, row};
    assign clip     = (px >= SCR_W) || (py >= SCR_H);
    assign last_pix = (col == cur.w - XW'(1)) && (row == cur.h - YW'(1));
    assign busy     = (state != IDLE);

`ifdef GLYPH_MASK_EN
    logic [99:0] mask;
    logic [6:0]  pix_idx;        // counts 99 down to 0, then sticks at 0
    assign pix_color = mask[pix_idx] ? cur.color : 3'b000;
`else
    assign pix_color = cur.color;
`endif

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // Next state. DRAW includes one trailing cycle with pend low before DONE.
    // That cycle places done at E+1+w*h. For an empty rectangle it is the
    // only DRAW cycle, so done lands at E+1 and no pixel is emitted.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (win_vld) state_nx = DRAW;
            DRAW:    if (!pend)   state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Grant, raster walk and pixel output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt    <= '0;
            done   <= '0;
            plot   <= 1'b0;
            x      <= '0;
            y      <= '0;
            color  <= '0;
            ptr    <= '0;
            cur_oh <= '0;
            col    <= '0;
            row    <= '0;
            pend   <= 1'b0;
`ifdef GLYPH_MASK_EN
            pix_idx <= 7'd99;
`endif
        end else begin
            // NOTE: non-blocking assignments throughout, so every register here samples pre-edge values like real flops.
            gnt  <= '0;
            done <= '0;
            plot <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        gnt    <= win_oh;
                        cur_oh <= win_oh;
                        ptr    <= rr_add(win, 1);
                        col    <= '0;
                        row    <= '0;
                        pend   <= (slot.w != '0) && (slot.h != '0);
`ifdef GLYPH_MASK_EN
                        pix_idx <= 7'd99;
`endif
                    end
                end
                DRAW: begin
                    if (pend) begin
                        x     <= px[XW-1:0];
                        y     <= py[YW-1:0];
                        color <= pix_color;
                        plot  <= !clip;     // clipped pixels still use their cycle
                        pend  <= !last_pix;
                        if (col == cur.w - XW'(1)) begin
                            col <= '0;
                            row <= row + YW'(1);
                        end else begin
                            col <= col + XW'(1);
                        end
`ifdef GLYPH_MASK_EN
                        if (pix_idx != 7'd0) pix_idx <= pix_idx - 7'd1;
`endif
                    end else begin
                        done <= cur_oh;
                    end
                end
                default: ;
            endcase
        end
    end

    // Descriptor latch. Nothing reads it until a grant has loaded it.
    // NOTE: this storage has no reset; it is always written before use, and leaving the reset off keeps it plain flops.
    always_ff @(posedge clk) begin
        if (state == IDLE && win_vld) begin
            cur <= slot;
`ifdef GLYPH_MASK_EN
            mask <= req_mask[int'(win)*100 +: 100];
`endif
        end
    end

endmodule
